// File: rtl/lcd_cmd_issuer.sv
// Command-side transmitter for LCD_CTRL: fetches 3-bit commands from a synchronous ROM,
// strobes them out around busy, then waits for done. Optional busy watchdog: LCD_CMD_TIMEOUT_EN.
module lcd_cmd_issuer #(
    parameter int CMD_N   = 45,
    parameter int CMD_AW  = 6,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              cmd_cen,
    output logic [CMD_AW-1:0] cmd_a,
    input  logic [2:0]        cmd_q,
    input  logic              busy,
    input  logic              done,
    output logic [2:0]        cmd,
    output logic              cmd_valid,
    output logic [CMD_AW:0]   issued_cnt,
    output logic              finished,
    output logic              timeout
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_LOAD     = 3'd2,
        S_ISSUE    = 3'd3,
        S_GUARD    = 3'd4,
        S_WAIT     = 3'd5,
        S_DONEWAIT = 3'd6
    } state_t;

    localparam logic [CMD_AW:0]   CNT_LAST = (CMD_AW+1)'(CMD_N);
    localparam logic [CMD_AW:0]   CNT_ONE  = (CMD_AW+1)'(1);
    localparam logic [CMD_AW-1:0] ADDR_ONE = CMD_AW'(1);

    if (CMD_N < 1 || CMD_N > 2**CMD_AW || TIMEOUT < 1) begin : g_param_check
        $error("lcd_cmd_issuer: CMD_N must be 1..2**CMD_AW and TIMEOUT at least 1");
    end

    state_t              state_r, state_s;
    logic                cen_s;
    logic [CMD_AW-1:0]   addr_s;
    logic [2:0]          cmd_s;
    logic [CMD_AW:0]     cnt_s;
    logic                fin_s;
    logic                tmo_s;
    logic                strobe_s;
    logic                tmo_hit_s;

`ifdef LCD_CMD_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    logic [TW-1:0] tmo_cnt_r;
    logic          busy_wait_s;

    assign busy_wait_s = busy && ((state_r == S_ISSUE) || (state_r == S_WAIT));
    assign tmo_hit_s   = busy_wait_s && (tmo_cnt_r == TMO_LAST);

    // Busy watchdog: counts consecutive busy cycles while waiting to issue or to proceed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (busy_wait_s) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end else begin
            tmo_cnt_r <= {TW{1'b0}};
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state and next-output decode; the strobe is combinational so it tracks busy in the same cycle.
    always_comb begin
        state_s  = state_r;
        cen_s    = 1'b1;
        addr_s   = cmd_a;
        cmd_s    = cmd;
        cnt_s    = issued_cnt;
        fin_s    = finished;
        tmo_s    = timeout;
        strobe_s = 1'b0;
        if (done && (state_r != S_IDLE) && (state_r != S_DONEWAIT)) begin
            // early termination: keep issued_cnt and cmd_a as they are
            fin_s   = 1'b1;
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        cnt_s   = {(CMD_AW+1){1'b0}};
                        fin_s   = 1'b0;
                        tmo_s   = 1'b0;
                        addr_s  = {CMD_AW{1'b0}};
                        cen_s   = 1'b0;
                        state_s = S_FETCH;
                    end else if (done) begin
                        fin_s = 1'b1;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_FETCH: begin
                    state_s = S_LOAD;
                end
                S_LOAD: begin
                    cmd_s   = cmd_q;
                    state_s = S_ISSUE;
                end
                S_ISSUE: begin
                    if (tmo_hit_s) begin
                        tmo_s   = 1'b1;
                        state_s = S_IDLE;
                    end else if (!busy) begin
                        strobe_s = 1'b1;
                        cnt_s    = issued_cnt + CNT_ONE;
                        state_s  = S_GUARD;
                    end else begin
                        state_s = S_ISSUE;
                    end
                end
                S_GUARD: begin
                    state_s = S_WAIT;
                end
                S_WAIT: begin
                    if (tmo_hit_s) begin
                        tmo_s   = 1'b1;
                        state_s = S_IDLE;
                    end else if (busy) begin
                        state_s = S_WAIT;
                    end else if (issued_cnt == CNT_LAST) begin
                        state_s = S_DONEWAIT;
                    end else begin
                        addr_s  = cmd_a + ADDR_ONE;
                        cen_s   = 1'b0;
                        state_s = S_FETCH;
                    end
                end
                S_DONEWAIT: begin
                    if (done) begin
                        fin_s   = 1'b1;
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_DONEWAIT;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    assign cmd_valid = strobe_s;

    // State and registered outputs; reset aborts a run at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            cmd_cen    <= 1'b1;
            cmd_a      <= {CMD_AW{1'b0}};
            cmd        <= 3'd0;
            issued_cnt <= {(CMD_AW+1){1'b0}};
            finished   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_r    <= state_s;
            cmd_cen    <= cen_s;
            cmd_a      <= addr_s;
            cmd        <= cmd_s;
            issued_cnt <= cnt_s;
            finished   <= fin_s;
            timeout    <= tmo_s;
        end
    end

endmodule
